// File: rtl/pong_draw_scheduler_if.sv
// Draw-request bus between the Pong game objects and the draw scheduler.
//   req/rect_*    : per-requester draw request and rectangle description,
//                   requester i in slice [i*W +: W] (0=border, 1=paddle1,
//                   2=paddle2, 3=ball)
//   stall         : pixel-sink backpressure, 1 holds the scan
//   gnt/done      : one-hot grant and one-cycle completion pulse
//   busy          : scheduler not idle
//   plot/x/y/colour : pixel write strobe and pixel data for the VGA adapter
// Modports: master = requesters and pixel sink, slave = scheduler.
interface pong_draw_scheduler_if #(
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int CW = 3
);
  logic [3:0]      req;
  logic [4*XW-1:0] rect_x;
  logic [4*YW-1:0] rect_y;
  logic [4*XW-1:0] rect_w;
  logic [4*YW-1:0] rect_h;
  logic [4*CW-1:0] rect_colour;
  logic            stall;
  logic [3:0]      gnt;
  logic [3:0]      done;
  logic            busy;
  logic            plot;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [CW-1:0]   colour;

  modport master (
    output req, rect_x, rect_y, rect_w, rect_h, rect_colour, stall,
    input  gnt, done, busy, plot, x, y, colour
  );

  modport slave (
    input  req, rect_x, rect_y, rect_w, rect_h, rect_colour, stall,
    output gnt, done, busy, plot, x, y, colour
  );
endinterface

// File: rtl/pong_draw_scheduler.sv
// Pong draw scheduler: arbitrates between four rectangle draw requesters and
// scans the granted rectangle row by row into pixel writes for the VGA adapter.
// Ports:
//   clk : clock, all state on rising edge
//   rst : asynchronous active-low reset
//   bus : pong_draw_scheduler_if.slave (requests, rectangles, stall in;
//         gnt, done, busy, plot, x, y, colour out -- all registered)
// Build option: define DRAW_SCHED_ROUND_ROBIN_EN for round-robin arbitration
// (search starts after the last winner); otherwise fixed priority, req[0]
// highest.
module pong_draw_scheduler #(
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int CW = 3
) (
  input logic                  clk,
  input logic                  rst,
  pong_draw_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;

  logic [3:0]    r_gnt,    w_gnt_nxt;
  logic [3:0]    r_done,   w_done_nxt;
  logic          r_busy,   w_busy_nxt;
  logic          r_plot,   w_plot_nxt;
  logic [XW-1:0] r_x,      w_x_nxt;
  logic [YW-1:0] r_y,      w_y_nxt;
  logic [CW-1:0] r_colour, w_colour_nxt;

  // Latched rectangle and scan counters
  logic [XW-1:0] r_x0, w_x0_nxt;
  logic [YW-1:0] r_y0, w_y0_nxt;
  logic [XW-1:0] r_w,  w_w_nxt;
  logic [YW-1:0] r_h,  w_h_nxt;
  logic [CW-1:0] r_col, w_col_nxt;
  logic [XW-1:0] r_cx, w_cx_nxt;
  logic [YW-1:0] r_cy, w_cy_nxt;

  logic [1:0]    w_win;
  logic          w_grant;

  // Arbitration: the last assignment in the descending loop is the first
  // requester in search order.
`ifdef DRAW_SCHED_ROUND_ROBIN_EN
  logic [1:0] r_ptr;
  logic [1:0] w_idx;

  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      w_idx = r_ptr + 2'(i);
      if (bus.req[w_idx]) w_win = w_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_ptr <= 2'd3;
    else if (w_grant) r_ptr <= w_win;
  end
`else
  always_comb begin
    w_win = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (bus.req[i-1]) w_win = 2'(i-1);
    end
  end
`endif

  logic [XW-1:0] w_sel_x, w_sel_w;
  logic [YW-1:0] w_sel_y, w_sel_h;
  logic [CW-1:0] w_sel_c;

  assign w_sel_x = bus.rect_x[int'(w_win)*XW +: XW];
  assign w_sel_w = bus.rect_w[int'(w_win)*XW +: XW];
  assign w_sel_y = bus.rect_y[int'(w_win)*YW +: YW];
  assign w_sel_h = bus.rect_h[int'(w_win)*YW +: YW];
  assign w_sel_c = bus.rect_colour[int'(w_win)*CW +: CW];

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_done_nxt   = '0;
    w_plot_nxt   = 1'b0;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_colour_nxt = r_colour;
    w_x0_nxt     = r_x0;
    w_y0_nxt     = r_y0;
    w_w_nxt      = r_w;
    w_h_nxt      = r_h;
    w_col_nxt    = r_col;
    w_cx_nxt     = r_cx;
    w_cy_nxt     = r_cy;
    w_grant      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_grant   = 1'b1;
          w_gnt_nxt = 4'b0001 << w_win;
          w_x0_nxt  = w_sel_x;
          w_y0_nxt  = w_sel_y;
          w_w_nxt   = w_sel_w;
          w_h_nxt   = w_sel_h;
          w_col_nxt = w_sel_c;
          w_cx_nxt  = '0;
          w_cy_nxt  = '0;
          // Zero-area rectangles skip the scan but still complete via FIN
          if (w_sel_w == '0 || w_sel_h == '0) w_state_nxt = FIN;
          else                                w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (!bus.stall) begin
          w_plot_nxt   = 1'b1;
          w_x_nxt      = r_x0 + r_cx;
          w_y_nxt      = r_y0 + r_cy;
          w_colour_nxt = r_col;
          if (r_cx == r_w - XW'(1)) begin
            w_cx_nxt = '0;
            if (r_cy == r_h - YW'(1)) w_state_nxt = FIN;
            else                      w_cy_nxt    = r_cy + YW'(1);
          end else begin
            w_cx_nxt = r_cx + XW'(1);
          end
        end
      end
      FIN: begin
        w_done_nxt  = r_gnt;
        w_gnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt    <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_plot   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_col    <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
    end else begin
      r_gnt    <= w_gnt_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
      r_plot   <= w_plot_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_colour <= w_colour_nxt;
      r_x0     <= w_x0_nxt;
      r_y0     <= w_y0_nxt;
      r_w      <= w_w_nxt;
      r_h      <= w_h_nxt;
      r_col    <= w_col_nxt;
      r_cx     <= w_cx_nxt;
      r_cy     <= w_cy_nxt;
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.done   = r_done;
  assign bus.busy   = r_busy;
  assign bus.plot   = r_plot;
  assign bus.x      = r_x;
  assign bus.y      = r_y;
  assign bus.colour = r_colour;

endmodule

// File: tb/tb_pong_draw_scheduler.sv
// Self-checking bench for pong_draw_scheduler: constant vector table,
// hand-written corner sequences and randomized rectangles against a
// pixel-list reference model.
module tb_pong_draw_scheduler;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pong_draw_scheduler_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

  pong_draw_scheduler #(.XW(XW), .YW(YW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
  } pix_t;

  typedef struct {
    logic [3:0] req;
    int x0, y0, w, h, c;
    logic [3:0] gnt;
    int n, fx, fy, lx, ly, lat;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XW-1:0] sx0 [4];
  logic [YW-1:0] sy0 [4];
  logic [XW-1:0] sw  [4];
  logic [YW-1:0] sh  [4];
  logic [CW-1:0] sc  [4];

  pix_t obs_q [$];
  int   m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_rects();
    for (int i = 0; i < 4; i++) begin
      bus.rect_x[i*XW +: XW]      = sx0[i];
      bus.rect_y[i*YW +: YW]      = sy0[i];
      bus.rect_w[i*XW +: XW]      = sw[i];
      bus.rect_h[i*YW +: YW]      = sh[i];
      bus.rect_colour[i*CW +: CW] = sc[i];
    end
  endtask

  task automatic random_slot(input int i);
    sx0[i] = XW'($urandom);
    sy0[i] = YW'($urandom);
    sw[i]  = XW'($urandom_range(0, 5));
    sh[i]  = YW'($urandom_range(0, 4));
    sc[i]  = CW'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    bus.req   = '0;
    bus.stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference arbitration from the last-winner bookkeeping
  function automatic int m_pick(input logic [3:0] r);
`ifdef DRAW_SCHED_ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) if (r[(m_last + k) % 4]) return (m_last + k) % 4;
`else
    for (int k = 0; k < 4; k++) if (r[k]) return k;
`endif
    return 0;
  endfunction

  // One request: drive req, capture grant, scramble inputs after the grant,
  // collect plotted pixels until done. Latency counts negedges after grant.
  task automatic run_txn(input logic [3:0] req_v, input int stall_pct, input string tag,
                         output logic [3:0] g, output int lat);
    int cyc;
    bit seen;
    bit held_ok;
    obs_q.delete();
    bus.req   = req_v;
    bus.stall = 1'b0;
    @(negedge clk);
    g = bus.gnt;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    bus.req = '0;
    for (int i = 0; i < 4; i++) random_slot(i);
    drive_rects();
    held_ok = 1'b1;
    seen    = 1'b0;
    cyc     = 0;
    lat     = 0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.plot) obs_q.push_back({bus.x, bus.y, bus.colour});
      if (bus.done != 4'b0) begin
        seen = 1'b1;
        lat  = cyc;
        check({tag, "_done"}, 32'(bus.done), 32'(g));
        check({tag, "_gnt_clr"}, 32'(bus.gnt), 32'd0);
        check({tag, "_busy_clr"}, 32'(bus.busy), 32'd0);
      end else if (bus.gnt !== g) begin
        held_ok = 1'b0;
      end
      bus.stall = ($urandom_range(0, 99) < stall_pct);
    end
    bus.stall = 1'b0;
    check({tag, "_timeout"}, 32'(seen), 32'd1);
    check({tag, "_gnt_held"}, 32'(held_ok), 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  vec_t tbl [7];

  initial begin
    logic [3:0] g;
    int lat, win, np, cyc, ng;
    pix_t e;
    pix_t exp_q [$];
    logic [3:0] arb_exp [5];
    logic [3:0] prev;

    bus.req = '0;
    bus.stall = 1'b0;
    for (int i = 0; i < 4; i++) random_slot(i);
    drive_rects();

    tbl[0] = '{4'b0010, 10, 20, 3, 2, 5, 4'b0010, 6, 10, 20, 12, 21, 7};
    tbl[1] = '{4'b1000, 510, 7, 4, 1, 3, 4'b1000, 4, 510, 7, 1, 7, 5};
    tbl[2] = '{4'b0100, 100, 50, 0, 5, 2, 4'b0100, 0, 0, 0, 0, 0, 1};
    tbl[3] = '{4'b0001, 30, 40, 2, 0, 7, 4'b0001, 0, 0, 0, 0, 0, 1};
    tbl[4] = '{4'b1010, 0, 255, 1, 2, 6, 4'b0010, 2, 0, 255, 0, 0, 3};
    tbl[5] = '{4'b1111, 5, 5, 2, 2, 1, 4'b0001, 4, 5, 5, 6, 6, 5};
    tbl[6] = '{4'b1100, 1, 2, 1, 1, 4, 4'b0100, 1, 1, 2, 1, 2, 2};

    // Reset state
    #12;
    check("rst_state", {bus.gnt, bus.done, bus.busy, bus.plot, bus.x, bus.y, bus.colour}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Vector table, each from reset so both arbitration schemes agree
    for (int v = 0; v < 7; v++) begin
      do_reset();
      for (int i = 0; i < 4; i++) random_slot(i);
      win = onehot_idx(tbl[v].gnt);
      sx0[win] = XW'(tbl[v].x0);
      sy0[win] = YW'(tbl[v].y0);
      sw[win]  = XW'(tbl[v].w);
      sh[win]  = YW'(tbl[v].h);
      sc[win]  = CW'(tbl[v].c);
      drive_rects();
      run_txn(tbl[v].req, 0, $sformatf("vec%0d", v), g, lat);
      check($sformatf("vec%0d_gnt", v), 32'(g), 32'(tbl[v].gnt));
      check($sformatf("vec%0d_nplot", v), obs_q.size(), tbl[v].n);
      check($sformatf("vec%0d_lat", v), lat, tbl[v].lat);
      if (tbl[v].n > 0 && obs_q.size() > 0) begin
        check($sformatf("vec%0d_first", v), {obs_q[0].x, obs_q[0].y}, {XW'(tbl[v].fx), YW'(tbl[v].fy)});
        check($sformatf("vec%0d_last", v), {obs_q[$].x, obs_q[$].y}, {XW'(tbl[v].lx), YW'(tbl[v].ly)});
        foreach (obs_q[k]) check($sformatf("vec%0d_col%0d", v, k), 32'(obs_q[k].c), 32'(tbl[v].c));
      end
    end

    // Three stalled cycles in the middle of a 4x1 rectangle
    do_reset();
    for (int i = 0; i < 4; i++) random_slot(i);
    sx0[3] = 9'd100; sy0[3] = 8'd9; sw[3] = 9'd4; sh[3] = 8'd1; sc[3] = 3'd2;
    drive_rects();
    bus.req = 4'b1000;
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    check("stall_p0", {bus.plot, bus.x}, {1'b1, 9'd100});
    @(negedge clk);
    check("stall_p1", {bus.plot, bus.x}, {1'b1, 9'd101});
    bus.stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check($sformatf("stall_hold%0d", s), {bus.plot, bus.x, bus.y, bus.colour}, {1'b0, 9'd101, 8'd9, 3'd2});
    end
    bus.stall = 1'b0;
    @(negedge clk);
    check("stall_p2", {bus.plot, bus.x}, {1'b1, 9'd102});
    @(negedge clk);
    check("stall_p3", {bus.plot, bus.x}, {1'b1, 9'd103});
    @(negedge clk);
    check("stall_done", {bus.plot, bus.done}, {1'b0, 4'b1000});

    // All requesters held with 1x1 rectangles: grant order
    do_reset();
    for (int i = 0; i < 4; i++) begin
      random_slot(i);
      sw[i] = 9'd1;
      sh[i] = 8'd1;
    end
    drive_rects();
`ifdef DRAW_SCHED_ROUND_ROBIN_EN
    arb_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    arb_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    bus.req = 4'b1111;
    prev = '0;
    ng = 0;
    cyc = 0;
    while (ng < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt != 4'b0 && prev == 4'b0) begin
        check($sformatf("arb_grant%0d", ng), 32'(bus.gnt), 32'(arb_exp[ng]));
        ng++;
      end
      prev = bus.gnt;
    end
    check("arb_count", ng, 5);
    bus.req = '0;
    repeat (5) @(negedge clk);

    // Reset asserted while the third of six pixels is on the outputs
    do_reset();
    for (int i = 0; i < 4; i++) random_slot(i);
    sx0[1] = 9'd10; sy0[1] = 8'd20; sw[1] = 9'd3; sh[1] = 8'd2; sc[1] = 3'd5;
    drive_rects();
    bus.req = 4'b0010;
    np = 0;
    cyc = 0;
    while (np < 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (bus.plot) np++;
    end
    check("midrst_reach3", np, 3);
    #2 rst = 1'b0;
    #1;
    check("midrst_outs", {bus.gnt, bus.done, bus.busy, bus.plot, bus.x, bus.y, bus.colour}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    while (!bus.plot && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_restart", {bus.plot, bus.x, bus.y, bus.colour}, {1'b1, 9'd10, 8'd20, 3'd5});
    bus.req = '0;
    cyc = 0;
    while (bus.done == 4'b0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_done", 32'(bus.done), 32'b0010);

    // Randomized rectangles with random stalls against the pixel-list model
    do_reset();
    m_last = 3;
    for (int t = 0; t < 40; t++) begin
      logic [3:0] rq;
      for (int i = 0; i < 4; i++) random_slot(i);
      drive_rects();
      rq  = 4'($urandom_range(1, 15));
      win = m_pick(rq);
      exp_q.delete();
      for (int yy = 0; yy < int'(sh[win]); yy++)
        for (int xx = 0; xx < int'(sw[win]); xx++) begin
          e.x = XW'((int'(sx0[win]) + xx) % (1 << XW));
          e.y = YW'((int'(sy0[win]) + yy) % (1 << YW));
          e.c = sc[win];
          exp_q.push_back(e);
        end
      run_txn(rq, 30, "rnd", g, lat);
      check($sformatf("rnd%0d_gnt", t), 32'(g), 32'(4'b0001 << win));
      check($sformatf("rnd%0d_nplot", t), obs_q.size(), exp_q.size());
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
        check($sformatf("rnd%0d_pix%0d", t, k), 32'(obs_q[k]), 32'(exp_q[k]));
      m_last = win;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
